alu_arbiter: RTL

Round-robin arbiter and two-stage issue pipeline that shares one combinational `alu` among `N_REQ` requesters. Each requester presents operands and a function code under a valid/ready handshake. The block serialises accepted operations through the `alu` and returns the registered result, flags and requester ID on one shared response port with backpressure. It sits between the requesting units and the single `alu` instance.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu.sv | 50 +++++
 rtl/rr_arbiter.sv | 32 +++
 rtl/alu_arbiter.sv | 110 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its round-robin issue arbiter.
package alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic overflow;
    logic carry;
    logic negative;
  } alu_flags_t;

endpackage

// File: rtl/alu.sv
// Purely combinational 32-bit ALU with zero/overflow/carry/negative flags.
module alu
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        f,
  output logic [DATA_W-1:0] result,
  output alu_flags_t        flags
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic            carry;
  logic            overflow;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Subtraction is a + ~b + 1, so carry reads as "no borrow".
  assign diff = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (f)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: begin
        result   = sum[DATA_W-1:0];
        carry    = sum[DATA_W];
        overflow = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        result   = diff[DATA_W-1:0];
        carry    = diff[DATA_W];
        overflow = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

  always_comb begin
    flags.zero     = (result == '0);
    flags.overflow = overflow;
    flags.carry    = carry;
    flags.negative = result[DATA_W-1];
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id
);

  int   idx;
  logic found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among N_REQ requesters through a two-stage pipeline:
// stage 1 holds the granted operands, stage 2 is the registered response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*32-1:0] req_a,
  input  logic [N_REQ*32-1:0] req_b,
  input  logic [N_REQ*3-1:0] req_f,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic [31:0]        rsp_result,
  output logic               rsp_zero,
  output logic               rsp_overflow,
  output logic               rsp_carry,
  output logic               rsp_negative,
  output logic [31:0]        op_count
);

  logic              s1_valid;
  logic [31:0]       s1_a;
  logic [31:0]       s1_b;
  logic [2:0]        s1_f;
  logic [ID_W-1:0]   s1_id;
  logic [ID_W-1:0]   rr_ptr;
  logic              s1_load;
  logic              s2_load;
  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_id;
  logic              grant;
  logic [31:0]       alu_result;
  alu_flags_t        alu_flags;

  // rsp_ready reaches req_ready combinationally so a drained slot refills at once.
  assign s2_load = s1_valid && (!rsp_valid || rsp_ready);
  assign s1_load = !s1_valid || s2_load;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .en     (s1_load && !reset),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign req_ready = gnt;
  assign grant     = |gnt;

  alu u_alu (
    .a      (s1_a),
    .b      (s1_b),
    .f      (s1_f),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_f     <= '0;
      s1_id    <= '0;
      rr_ptr   <= '0;
    end else if (s1_load) begin
      s1_valid <= grant;
      if (grant) begin
        s1_a   <= req_a[32*gnt_id +: 32];
        s1_b   <= req_b[32*gnt_id +: 32];
        s1_f   <= req_f[3*gnt_id +: 3];
        s1_id  <= gnt_id;
        rr_ptr <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_negative <= 1'b0;
      op_count     <= '0;
    end else begin
      if (s2_load) begin
        rsp_valid    <= 1'b1;
        rsp_id       <= s1_id;
        rsp_result   <= alu_result;
        rsp_zero     <= alu_flags.zero;
        rsp_overflow <= alu_flags.overflow;
        rsp_carry    <= alu_flags.carry;
        rsp_negative <= alu_flags.negative;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (rsp_valid && rsp_ready) op_count <= op_count + 32'd1;
    end
  end

endmodule
